muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_seq.sv | 130 +++++++++++++
 tb/tb_muldiv_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake and HI/LO bus between the pipeline and the sequential multiply/divide unit.
// The pipeline drives the master modport; muldiv_seq drives the slave modport.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_rd;
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;
    logic             stall;

    modport master (
        output start, op, a, b, hilo_rd, hilo_we, wdata,
        input  hi, lo, busy, done, div0, stall
    );

    modport slave (
        input  start, op, a, b, hilo_rd, hilo_we, wdata,
        output hi, lo, busy, done, div0, stall
    );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 sequential MIPS-style mult/multu/div/divu unit with HI/LO registers.
// Fixed 33-cycle latency: one load edge, 32 step edges, one sign-fix/writeback edge.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a_raw;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div0;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_cand;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_next;
    logic               w_neg_res;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div0;

    // op[0] clear selects the signed variants
    assign w_neg_a = ~bus.op[0] & bus.a[WIDTH-1];
    assign w_neg_b = ~bus.op[0] & bus.b[WIDTH-1];
    assign w_abs_a = w_neg_a ? -bus.a : bus.a;
    assign w_abs_b = w_neg_b ? -bus.b : bus.b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step
    assign w_div_cand = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_cand - {1'b0, r_m};
    assign w_div_ok   = ~w_div_diff[WIDTH];
    assign w_div_next = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_cand[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ok};

    assign w_neg_res = r_sa ^ r_sb;
    assign w_prod    = w_neg_res ? -r_acc : r_acc;
    assign w_quo     = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem     = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_div0    = r_op[1] & (r_m == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_m     <= '0;
            r_a_raw <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hilo_we[1]) r_hi <= bus.wdata;
                    if (bus.hilo_we[0]) r_lo <= bus.wdata;
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_sa    <= w_neg_a;
                        r_sb    <= w_neg_b;
                        r_a_raw <= bus.a;
                        // r_m holds the addend for multiply and the divisor for divide
                        r_m     <= bus.op[1] ? w_abs_b : w_abs_a;
                        r_acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (w_div0) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_done  <= 1'b1;
                    r_div0  <= w_div0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = r_done;
    assign bus.div0  = r_div0;
    assign bus.stall = bus.busy & (bus.hilo_rd | bus.start | (bus.hilo_we != 2'b00));
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of operations with hand-computed HI/LO,
// plus sequences for stall, mthi/mtlo, simultaneous start/write and mid-run reset.
module tb_muldiv_seq;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Launch one operation (optionally with mthi/mtlo on the same edge) and check the result
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] we, input logic [31:0] wd,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          lat;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.a       = a;
        bus.b       = b;
        bus.hilo_we = we;
        bus.wdata   = wd;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.hilo_we = 2'b00;
        pre_hi = bus.hi;
        pre_lo = bus.lo;
        chk({nm, " busy after start"}, 64'(bus.busy), 64'd1);
        if (we[1]) chk({nm, " mthi with start"}, 64'(bus.hi), 64'(wd));
        if (we[0]) chk({nm, " mtlo with start"}, 64'(bus.lo), 64'(wd));
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 16) chk({nm, " hilo held"}, {bus.hi, bus.lo}, {pre_hi, pre_lo});
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, 64'(lat), 64'd33);
        chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, " lo"}, 64'(bus.lo), 64'(el));
        chk({nm, " div0"}, 64'(bus.div0), 64'(ed));
        chk({nm, " busy after done"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        chk({nm, " done one cycle"}, {62'd0, bus.done, bus.div0}, 64'd0);
    endtask

    initial begin
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          lat;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[6]  = '{2'b00, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
        vecs[7]  = '{2'b00, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000000, 32'h00000020, 1'b0};
        vecs[8]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[12] = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};

        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.hilo_rd = 1'b0;
        bus.hilo_we = 2'b00;
        bus.wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {bus.hi, bus.lo}, 64'd0);
        chk("reset flags", {60'd0, bus.busy, bus.done, bus.div0, bus.stall}, 64'd0);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 2'b00, 32'd0,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        // mtlo then mthi in IDLE
        @(negedge clk);
        pre_hi      = bus.hi;
        bus.hilo_we = 2'b01;
        bus.wdata   = 32'h00001234;
        @(posedge clk);
        #1;
        bus.hilo_we = 2'b00;
        chk("mtlo lo", 64'(bus.lo), 64'h1234);
        chk("mtlo hi untouched", 64'(bus.hi), 64'(pre_hi));
        @(negedge clk);
        bus.hilo_we = 2'b10;
        bus.wdata   = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.hilo_we = 2'b00;
        chk("mthi hi", {bus.hi, bus.lo}, 64'hCAFEF00D_00001234);

        // Reads and new requests during RUN must stall and be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'hFFFFFFFD;
        bus.b     = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pre_hi = bus.hi;
        pre_lo = bus.lo;
        repeat (4) @(posedge clk);
        #1;
        bus.hilo_rd = 1'b1;
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.a       = 32'd100;
        bus.b       = 32'd7;
        bus.hilo_we = 2'b11;
        bus.wdata   = 32'hDEADBEEF;
        #1;
        chk("stall asserted", 64'(bus.stall), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall cycle %0d", k), 64'(bus.stall), 64'd1);
        end
        bus.start   = 1'b0;
        bus.hilo_we = 2'b00;
        chk("hilo ignored while busy", {bus.hi, bus.lo}, {pre_hi, pre_lo});
        lat = 0;
        for (int k = 10; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("stalled op latency", 64'(lat), 64'd33);
        chk("stalled op result", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
        chk("stall low when idle", 64'(bus.stall), 64'd0);
        bus.hilo_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("second start not relaunched", 64'(bus.busy), 64'd0);

        // Simultaneous mthi/mtlo and start: write at E0, result overwrites at E33
        run_op("start+we", 2'b01, 32'd3, 32'd4, 2'b11, 32'h00000055,
               32'h00000000, 32'h0000000C, 1'b0);

        // Asynchronous reset mid-multiply
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd123;
        bus.b     = 32'd456;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async reset hilo", {bus.hi, bus.lo}, 64'd0);
        chk("async reset flags", {61'd0, bus.busy, bus.done, bus.div0}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset held no done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        run_op("post-reset divu", 2'b11, 32'd100, 32'd7, 2'b00, 32'd0, 32'd2, 32'd14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
